// File: rtl/pwr_pkg.sv
// pwr_pkg: shared power-state encodings for the S3 sequencer.
package pwr_pkg;
  localparam int PWR_STATE_W = 3;
  typedef enum logic [PWR_STATE_W-1:0] {
    ST_ACTIVE  = 3'd0,
    ST_SAVE    = 3'd1,
    ST_S3      = 3'd2,
    ST_RESTORE = 3'd3,
    ST_RESUME  = 3'd4
  } pwr_state_e;
endpackage

// File: rtl/pwr_timer.sv
// pwr_timer: clearable up-counter that stops at i_max and flags reaching it.
module pwr_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_max,
  output logic             o_tc
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (r_cnt != i_max) r_cnt <= r_cnt + 1'b1;
  assign o_tc = (r_cnt == i_max);
endmodule

// File: rtl/s3_power_ctrl.sv
// s3_power_ctrl: S3 entry/exit sequencer driving ALU s3_state, clock gate and RAM save/restore.
// One shared timer restarts on every state change; its limit depends on the current state.
module s3_power_ctrl
  import pwr_pkg::*;
#(
  parameter int ENTRY_DELAY   = 4,
  parameter int MIN_S3_CYCLES = 8,
  parameter int RESUME_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 16,
  parameter int CNT_W         = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_idle,
  input  logic                   alu_interrupt,
  input  logic                   sleep_req,
  input  logic                   wake_req,
  input  logic                   ram_save_ack,
  input  logic                   ram_restore_ack,
  output logic                   s3_state,
  output logic                   clk_gate_en,
  output logic                   ram_save_req,
  output logic                   ram_restore_req,
  output logic [PWR_STATE_W-1:0] pwr_state,
  output logic                   wake_done,
  output logic                   err,
  output logic [7:0]             s3_entries
);
  pwr_state_e       r_state, w_next;
  logic             r_s3, r_cg, r_sreq, r_rreq, r_wd, r_err;
  logic [7:0]       r_ent;
  logic             w_int, w_tc, w_clr, w_save_ok, w_err_set;
  logic [CNT_W-1:0] w_max;
  // interrupt without idle is spurious and restarts the entry run
  assign w_int = alu_interrupt & alu_idle;
  always_comb begin
    w_max = (r_state == ST_ACTIVE) ? CNT_W'(ENTRY_DELAY - 1) :
            (r_state == ST_S3)     ? CNT_W'(MIN_S3_CYCLES - 1) :
            (r_state == ST_RESUME) ? CNT_W'(RESUME_CYCLES - 1) :
                                     CNT_W'(ACK_TIMEOUT - 1);
    w_next = r_state;
    case (r_state)
      ST_ACTIVE:  w_next = (sleep_req || (w_int && w_tc)) ? ST_SAVE : ST_ACTIVE;
      ST_SAVE:    w_next = ram_save_ack ? ST_S3 : w_tc ? ST_ACTIVE : ST_SAVE;
      ST_S3:      w_next = (wake_req && w_tc) ? ST_RESTORE : ST_S3;
      ST_RESTORE: w_next = (ram_restore_ack || w_tc) ? ST_RESUME : ST_RESTORE;
      ST_RESUME:  w_next = w_tc ? ST_ACTIVE : ST_RESUME;
      default:    w_next = ST_ACTIVE;
    endcase
    w_clr     = (w_next != r_state) || (r_state == ST_ACTIVE && !w_int);
    w_save_ok = (r_state == ST_SAVE) && ram_save_ack;
    w_err_set = (r_state == ST_SAVE && w_tc && !ram_save_ack) ||
                (r_state == ST_RESTORE && w_tc && !ram_restore_ack);
  end
  pwr_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_clr),
    .i_max (w_max),
    .o_tc  (w_tc)
  );
  // outputs are decoded from the next state so they change with the state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= ST_ACTIVE;
      r_s3    <= 1'b0;
      r_cg    <= 1'b1;
      r_sreq  <= 1'b0;
      r_rreq  <= 1'b0;
      r_wd    <= 1'b0;
      r_err   <= 1'b0;
      r_ent   <= 8'd0;
    end else begin
      r_state <= w_next;
      r_s3    <= (w_next == ST_SAVE) || (w_next == ST_S3) || (w_next == ST_RESTORE);
      r_cg    <= (w_next != ST_S3);
      r_sreq  <= (w_next == ST_SAVE);
      r_rreq  <= (w_next == ST_RESTORE);
      r_wd    <= (r_state == ST_RESUME) && w_tc;
      r_err   <= r_err || w_err_set;
      if (w_save_ok && r_ent != 8'hFF) r_ent <= r_ent + 8'd1;
    end
  assign s3_state        = r_s3;
  assign clk_gate_en     = r_cg;
  assign ram_save_req    = r_sreq;
  assign ram_restore_req = r_rreq;
  assign pwr_state       = r_state;
  assign wake_done       = r_wd;
  assign err             = r_err;
  assign s3_entries      = r_ent;
endmodule

// File: doc/s3_power_ctrl.md
Name: s3_power_ctrl

Overview:
- Power-state sequencer that consumes the ALU's idle/interrupt indications and produces the s3_state control the ALU uses to snapshot its operands.
- Coordinates the RAM context save/restore handshake and clock-gate enable on S3 entry and exit.
- Sits directly downstream of the ALU's idle detector and upstream of its s3_state input; the RAM save/restore port is driven from here.

Parameters:
- ENTRY_DELAY, 4, consecutive cycles alu_interrupt must be high before S3 entry starts (min 1)
- MIN_S3_CYCLES, 8, minimum dwell in S3 before wake_req is honoured
- RESUME_CYCLES, 2, settle cycles after restore before returning to ACTIVE (min 1)
- ACK_TIMEOUT, 16, max cycles waiting for a RAM ack before abort
- CNT_W, 5, width of internal counters; must hold max(ENTRY_DELAY, MIN_S3_CYCLES, RESUME_CYCLES, ACK_TIMEOUT)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- alu_idle  in  1  ALU idle indication
- alu_interrupt  in  1  ALU prolonged-idle interrupt
- sleep_req  in  1  software forced-sleep request, level
- wake_req  in  1  wake event, level
- ram_save_ack  in  1  RAM save complete
- ram_restore_ack  in  1  RAM restore complete
- s3_state  out  1  to ALU; high in SAVE, S3 and RESTORE
- clk_gate_en  out  1  1 = ALU/RAM clocks running; 0 only in S3
- ram_save_req  out  1  level request, held until ack or timeout
- ram_restore_req  out  1  level request, held until ack or timeout
- pwr_state  out  3  current state encoding
- wake_done  out  1  one-cycle pulse on RESUME->ACTIVE
- err  out  1  sticky; set on any ack timeout
- s3_entries  out  8  saturating count of S3 entries

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ACTIVE, all counters 0.
  - s3_state=0, clk_gate_en=1, both RAM requests 0.
  - pwr_state=0, wake_done=0, err=0, s3_entries=0.
- All outputs are registered, so every output reflects the current state with no combinational path from inputs.
- States (pwr_state): ACTIVE=0, SAVE=1, S3=2, RESTORE=3, RESUME=4. Encodings 5-7 are illegal and go to ACTIVE on the next clock.
- ACTIVE:
  - idle_cnt increments while alu_interrupt=1 and clears to 0 when alu_interrupt=0.
  - If sleep_req=1, or alu_interrupt=1 with idle_cnt==ENTRY_DELAY-1, go to SAVE next cycle.
  - sleep_req takes priority over wake_req. wake_req is ignored in ACTIVE.
  - alu_idle gates nothing; it only resets idle_cnt when low. alu_interrupt without alu_idle is treated as spurious.
- SAVE:
  - s3_state=1, ram_save_req=1, tmo_cnt counts.
  - ram_save_ack=1: go to S3, and s3_entries increments (saturates at 255).
  - Timeout (tmo_cnt==ACK_TIMEOUT-1 without ack): set err, drop ram_save_req, go to ACTIVE with s3_state=0.
  - Ack arriving on the timeout cycle wins (no error).
- S3:
  - clk_gate_en=0, s3_state=1, dwell_cnt counts and saturates at MIN_S3_CYCLES.
  - wake_req=1 with dwell_cnt>=MIN_S3_CYCLES: go to RESTORE.
  - wake_req held high through dwell is honoured on the first eligible cycle.
  - sleep_req is ignored in S3.
- RESTORE:
  - clk_gate_en=1, s3_state=1, ram_restore_req=1.
  - ram_restore_ack: go to RESUME.
  - Timeout: set err and still go to RESUME; the system must not stay asleep.
- RESUME:
  - s3_state=0, clk_gate_en=1.
  - After RESUME_CYCLES cycles, go to ACTIVE with wake_done=1 for exactly that one cycle.
  - idle_cnt clears, so re-entry requires a fresh ENTRY_DELAY run.
- Acks arriving in a state that does not expect them are ignored. A stale ack is never carried across states.
- Latency (alu_interrupt rising with idle_cnt=0, no sleep_req):
  - SAVE is entered ENTRY_DELAY cycles later.
  - Minimum full cycle ACTIVE->ACTIVE is 1 + MIN_S3_CYCLES + 1 + RESUME_CYCLES cycles with immediate acks.

Decomposition:
- Shared package pwr_pkg:
  - state enum/localparams for ACTIVE..RESUME
  - PWR_STATE_W=3
- One natural sub-module, pwr_timer: a loadable/clearable CNT_W counter with terminal-count flag. Instantiate it for idle, timeout, dwell and resume counting, or share one instance cleared on every state change.

Test Plan:
- Nominal entry/exit: alu_idle=alu_interrupt=1 for 4 cycles, save ack 2 cycles later, wake_req after 10 S3 cycles, restore ack after 1 cycle.
  - pwr_state goes 0->1->2->3->4->0; s3_state high through SAVE..RESTORE; clk_gate_en=0 only in S3.
  - wake_done pulses once; s3_entries=1.
- Interrupt glitch: alu_interrupt high 3 cycles, low 1, high 3 -> remains ACTIVE with no save request.
- Forced sleep plus early wake: sleep_req and wake_req together in ACTIVE -> SAVE. wake_req held from S3 cycle 0 -> RESTORE exactly at dwell 8.
- Save timeout: no ram_save_ack -> after 16 SAVE cycles, err=1 and return to ACTIVE; s3_entries unchanged. A later successful cycle leaves err=1.
- Restore timeout: no ram_restore_ack -> err=1, RESUME, then ACTIVE with wake_done pulse.
- Async reset mid-S3: assert reset between clock edges -> outputs immediately at reset values (clk_gate_en=1, s3_state=0); after release, ACTIVE.
